// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, reads instruction memory over a shared bus, buffers {pc, instr} pairs.
// Latency: a word read while re_o=1 appears on instr_o/valid_o one cycle later (memory is combinational).
// Backpressure: ready_i low fills the fetch buffer; re_o then drops and the PC holds until an entry pops.
module instr_fetch #(
   parameter int                    ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] addr_o,
   inout  wire  [31:0]           bus_io,
   output logic                  re_o,
   output logic                  we_o,
   input  logic                  start_i,
   input  logic                  halt_i,
   input  logic                  redirect_i,
   input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
   output logic [31:0]           instr_o,
   output logic [ADDR_WIDTH-1:0] pc_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  busy_o
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int EW = ADDR_WIDTH + 32;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   pc;
   logic [ADDR_WIDTH-1:0]   redirect_tgt;
   logic [EW-1:0]           buf_q [FIFO_DEPTH];
   logic [PW-1:0]           rd_ptr;
   logic [PW-1:0]           wr_ptr;
   logic [CW-1:0]           count;
   logic                    fetch;
   logic                    pop;

   // This block only listens on the shared bus; memory is the sole driver.
   assign bus_io = {32{1'bz}};
   assign we_o   = 1'b0;

   // Redirect targets are forced word aligned.
   assign redirect_tgt = redirect_pc_i & ~ADDR_WIDTH'(3);

   // A read is issued whenever running, not redirecting, and there is room to land the word.
   assign fetch   = (state == RUN) && !redirect_i && (count < DEPTH_C);
   assign re_o    = fetch;
   assign addr_o  = pc;
   assign valid_o = (count != '0);
   // A redirect flushes the buffer, so a handshake in that cycle is discarded.
   assign pop     = valid_o && ready_i && !redirect_i;
   assign busy_o  = (state == RUN) || valid_o;
   assign instr_o = buf_q[rd_ptr][31:0];
   assign pc_o    = buf_q[rd_ptr][EW-1:32];

   // Run/idle control; a redirect does not affect it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (start_i) state <= RUN;
            RUN:     if (halt_i)  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // PC: redirect wins over sequential advance; advance wraps at the address width.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc <= {RESET_PC[ADDR_WIDTH-1:2], 2'b00};
      end else if (redirect_i) begin
         pc <= redirect_tgt;
      end else if (fetch) begin
         pc <= pc + ADDR_WIDTH'(4);
      end
   end

   // Fetch buffer: push the sampled bus word with its PC, pop on handshake, flush on redirect.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            buf_q[i] <= '0;
         end
      end else if (redirect_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (fetch) begin
            buf_q[wr_ptr] <= {pc, bus_io};
            wr_ptr        <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (fetch && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !fetch) begin
            count <= count - CW'(1);
         end
      end
   end

   a_bus_known: assert property (@(posedge clk) disable iff (!rst_n) re_o |-> !$isunknown(bus_io));
   a_no_write:  assert property (@(posedge clk) !we_o);
   a_no_ovf:    assert property (@(posedge clk) disable iff (!rst_n) (count == DEPTH_C) |-> !fetch);

endmodule
